dff_timing_monitor: RTL and testbench
=====================================

DFF_TIMING_MONITOR -- requirements
Module: dff_timing_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of all interval counters.
REQ-002 SHALL have parameters T_SU=10, T_HD=1, T_PW=25, T_WPC=10, T_REC=5: limits in clock cycles.
REQ-003 SHALL have port clock, input, 1: single sampling clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports ff_clock, ff_data, ff_preset, ff_clear, input, 1 each: monitored flop pins, synchronous to clock.
REQ-006 SHALL have port clr_sticky, input, 1: clears sticky flags.
REQ-007 SHALL have port notifier, output, 1: toggles on each violation cycle.
REQ-008 SHALL have port viol, output, 5: one-cycle pulses {recovery, width, period, hold, setup} in bits [4:0].
REQ-009 SHALL have port sticky, output, 5: latched OR of viol, same bit order.

Function
REQ-010 SHALL detect edges by comparing each ff_* input with its value registered in the previous cycle; an edge is seen in the cycle the new value is first sampled.
REQ-011 SHALL keep saturating counters since_data, since_clk, since_prerise, since_clrrise, since_prefall, since_clrfall; each loads 0 in its event cycle, otherwise increments, saturating at 2^CNT_W-1.
REQ-012 SHALL define enable = ff_preset AND ff_clear, as sampled in the current cycle.
REQ-013 SHALL flag setup when a ff_clock rise occurs with enable=1 and the pre-update since_data < T_SU; a ff_data change in the same cycle SHALL count as distance 0.
REQ-014 SHALL flag hold when a ff_data change occurs with enable=1, no ff_clock rise in that cycle, and the pre-update since_clk < T_HD.
REQ-015 SHALL flag period when a ff_clock rise occurs with the pre-update since_clk < T_PW and a previous rise has been seen since reset.
REQ-016 SHALL flag width on a ff_preset rise with since_prefall < T_WPC, or on a ff_clear rise with since_clrfall < T_WPC.
REQ-017 SHALL flag recovery on a ff_clock rise with since_prerise < T_REC or since_clrrise < T_REC.
REQ-018 SHALL register viol one cycle after the detecting edge cycle; multiple bits MAY assert together.
REQ-019 SHALL invert notifier exactly once in any cycle where viol is non-zero, regardless of how many bits are set.
REQ-020 SHALL set each sticky bit when its viol bit is 1; clr_sticky SHALL clear sticky, but a viol bit in the same cycle SHALL win.
REQ-021 SHALL apply checks independently; one event MAY raise several checks.

Reset
REQ-022 SHALL drive notifier=0, viol=0, sticky=0 (and count=0 when present) in the cycle after reset is sampled high.
REQ-023 SHALL load all counters to saturation on reset so no check fires from pre-reset history.
REQ-024 SHALL, in the first cycle after reset deasserts, load the previous-sample registers from the inputs and suppress edge detection for that cycle.
REQ-025 SHALL abort all in-flight windows when reset is asserted mid-operation.

Configuration
REQ-026 SHALL, when DFF_TMON_COUNT_EN is defined, add output count (16 bits) that increments by 1 per non-zero viol cycle, saturates at 0xFFFF, and clears on reset or clr_sticky.
REQ-027 SHALL, without DFF_TMON_COUNT_EN, omit the count port and its logic; all other behaviour is unchanged.

Verification
REQ-028 SHALL cover setup: preset=clear=1, ff_data toggles 4 cycles before ff_clock rise -> viol=00001 one cycle after the rise, notifier toggles, sticky[0]=1.
REQ-029 SHALL cover hold and period: ff_clock rises at cycles 0 and 20, ff_data changes at cycle 0 -> setup only at cycle 0; period (bit 2) at cycle 20; no hold.
REQ-030 SHALL cover width and recovery: ff_preset falls at cycle 0 and rises at cycle 6, ff_clock rises at cycle 8 -> width at cycle 6, recovery at cycle 8; notifier toggles twice.
REQ-031 SHALL cover a clean run: 30-cycle clock period, data changes 15 cycles before each rise, enable=1 -> viol stays 0, notifier constant.
REQ-032 SHALL cover reset: assert reset one cycle after a data change, release it, then ff_clock rises 2 cycles later -> no setup violation; count=0 when DFF_TMON_COUNT_EN is defined.
REQ-033 SHALL cover clr_sticky colliding with a hold violation in the same cycle -> sticky[1] stays 1.

Source files
------------

// File: rtl/dff_timing_monitor.sv
// dff_timing_monitor: watches the pins of a flip-flop (clock, data, preset,
// clear), all sampled on the monitor clock, and flags setup, hold, clock
// period, preset/clear pulse width and preset/clear recovery violations.
// Optional feature macro: DFF_TMON_COUNT_EN adds a 16-bit saturating count
// of violation cycles.
module dff_timing_monitor #(
  parameter int CNT_W = 8,
  parameter int T_SU  = 10,
  parameter int T_HD  = 1,
  parameter int T_PW  = 25,
  parameter int T_WPC = 10,
  parameter int T_REC = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ff_clock,
  input  logic       ff_data,
  input  logic       ff_preset,
  input  logic       ff_clear,
  input  logic       clr_sticky,
  output logic       notifier,
  output logic [4:0] viol,
`ifdef DFF_TMON_COUNT_EN
  output logic [15:0] count,
`endif
  output logic [4:0] sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIM_SU  = CNT_W'(T_SU);
  localparam logic [CNT_W-1:0] LIM_HD  = CNT_W'(T_HD);
  localparam logic [CNT_W-1:0] LIM_PW  = CNT_W'(T_PW);
  localparam logic [CNT_W-1:0] LIM_WPC = CNT_W'(T_WPC);
  localparam logic [CNT_W-1:0] LIM_REC = CNT_W'(T_REC);

  logic prev_clk, prev_data, prev_pre, prev_clr;
  logic armed;
  logic seen_rise;

  logic [CNT_W-1:0] since_data, since_clk;
  logic [CNT_W-1:0] since_prerise, since_clrrise;
  logic [CNT_W-1:0] since_prefall, since_clrfall;

  logic clk_rise, data_chg, pre_rise, pre_fall, clr_rise, clr_fall;
  logic enable;
  logic setup_hit, hold_hit, period_hit, width_hit, rec_hit;
  logic [4:0] viol_d;

  // Counter step: zero on its event, otherwise count up and stick at max.
  function automatic logic [CNT_W-1:0] bump(input logic ev,
                                            input logic [CNT_W-1:0] v);
    if (ev)
      return '0;
    else if (v == CNT_MAX)
      return v;
    else
      return v + CNT_W'(1);
  endfunction

  // Edge detection against last cycle's samples; disabled until armed so the
  // first sample after reset never looks like an edge.
  always_comb begin
    clk_rise = armed & ff_clock & ~prev_clk;
    data_chg = armed & (ff_data ^ prev_data);
    pre_rise = armed & ff_preset & ~prev_pre;
    pre_fall = armed & ~ff_preset & prev_pre;
    clr_rise = armed & ff_clear & ~prev_clr;
    clr_fall = armed & ~ff_clear & prev_clr;
  end

  // Timing checks against the counter values from before this cycle's update.
  always_comb begin
    enable     = ff_preset & ff_clear;
    setup_hit  = clk_rise & enable & (data_chg | (since_data < LIM_SU));
    hold_hit   = data_chg & enable & ~clk_rise & (since_clk < LIM_HD);
    period_hit = clk_rise & seen_rise & (since_clk < LIM_PW);
    width_hit  = (pre_rise & (since_prefall < LIM_WPC)) |
                 (clr_rise & (since_clrfall < LIM_WPC));
    rec_hit    = clk_rise & ((since_prerise < LIM_REC) |
                             (since_clrrise < LIM_REC));
    viol_d     = {rec_hit, width_hit, period_hit, hold_hit, setup_hit};
  end

  // Previous-sample registers follow the inputs every cycle, reset included.
  always_ff @(posedge clock) begin
    prev_clk  <= ff_clock;
    prev_data <= ff_data;
    prev_pre  <= ff_preset;
    prev_clr  <= ff_clear;
  end

  // Interval counters and arming; reset saturates counters so stale history
  // can never trigger a check.
  always_ff @(posedge clock) begin
    if (reset) begin
      armed         <= 1'b0;
      seen_rise     <= 1'b0;
      since_data    <= CNT_MAX;
      since_clk     <= CNT_MAX;
      since_prerise <= CNT_MAX;
      since_clrrise <= CNT_MAX;
      since_prefall <= CNT_MAX;
      since_clrfall <= CNT_MAX;
    end else begin
      armed         <= 1'b1;
      seen_rise     <= seen_rise | clk_rise;
      since_data    <= bump(data_chg, since_data);
      since_clk     <= bump(clk_rise, since_clk);
      since_prerise <= bump(pre_rise, since_prerise);
      since_clrrise <= bump(clr_rise, since_clrrise);
      since_prefall <= bump(pre_fall, since_prefall);
      since_clrfall <= bump(clr_fall, since_clrfall);
    end
  end

  // Registered violation pulses, notifier toggle and sticky flags; a new
  // violation beats a simultaneous sticky clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      viol     <= '0;
      notifier <= 1'b0;
      sticky   <= '0;
    end else begin
      viol     <= viol_d;
      notifier <= notifier ^ (|viol_d);
      sticky   <= (clr_sticky ? 5'b00000 : sticky) | viol_d;
    end
  end

`ifdef DFF_TMON_COUNT_EN
  // Saturating count of cycles with any violation.
  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (clr_sticky)
      count <= {15'd0, |viol_d};
    else if ((|viol_d) && (count != 16'hFFFF))
      count <= count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dff_timing_monitor.sv
// tb_dff_timing_monitor: directed-vector bench for dff_timing_monitor.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_dff_timing_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic       ff_clock, ff_data, ff_preset, ff_clear, clr_sticky;
  logic       notifier;
  logic [4:0] viol, sticky;
`ifdef DFF_TMON_COUNT_EN
  logic [15:0] count;
`endif

  int vectors = 0;
  int miscompares = 0;

  dff_timing_monitor dut (
    .clock      (clock),
    .reset      (reset),
    .ff_clock   (ff_clock),
    .ff_data    (ff_data),
    .ff_preset  (ff_preset),
    .ff_clear   (ff_clear),
    .clr_sticky (clr_sticky),
    .notifier   (notifier),
    .viol       (viol),
`ifdef DFF_TMON_COUNT_EN
    .count      (count),
`endif
    .sticky     (sticky)
  );

  // Free-running monitor clock.
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    ff_clock = 1'b0; ff_data = 1'b0; ff_preset = 1'b1; ff_clear = 1'b1;
    clr_sticky = 1'b0;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    vectors++;
    if (viol !== 5'b00000) begin miscompares++; $display("[TB] FAIL reset_viol: got %b expected 00000", viol); end
    vectors++;
    if (notifier !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_notifier: got %b expected 0", notifier); end
    vectors++;
    if (sticky !== 5'b00000) begin miscompares++; $display("[TB] FAIL reset_sticky: got %b expected 00000", sticky); end
`ifdef DFF_TMON_COUNT_EN
    vectors++;
    if (count !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
`endif
  endtask

  task automatic test_setup;
    do_reset;
    ff_data = 1'b1; tick;
    vectors++;
    if (viol !== 5'b00000) begin miscompares++; $display("[TB] FAIL setup_pre: got %b expected 00000", viol); end
    tick; tick; tick;
    ff_clock = 1'b1; tick;
    vectors++;
    if (viol !== 5'b00001) begin miscompares++; $display("[TB] FAIL setup_viol: got %b expected 00001", viol); end
    vectors++;
    if (notifier !== 1'b1) begin miscompares++; $display("[TB] FAIL setup_notifier: got %b expected 1", notifier); end
    vectors++;
    if (sticky !== 5'b00001) begin miscompares++; $display("[TB] FAIL setup_sticky: got %b expected 00001", sticky); end
`ifdef DFF_TMON_COUNT_EN
    vectors++;
    if (count !== 16'd1) begin miscompares++; $display("[TB] FAIL setup_count: got %0d expected 1", count); end
`endif
    tick;
    vectors++;
    if (viol !== 5'b00000) begin miscompares++; $display("[TB] FAIL setup_pulse_end: got %b expected 00000", viol); end
    vectors++;
    if (sticky !== 5'b00001) begin miscompares++; $display("[TB] FAIL setup_sticky_hold: got %b expected 00001", sticky); end
  endtask

  task automatic test_setup_boundary;
    // Rise 11 cycles after the data change: counter reads 10, not a violation.
    do_reset;
    ff_data = 1'b1; tick;
    repeat (10) tick;
    ff_clock = 1'b1; tick;
    vectors++;
    if (viol !== 5'b00000) begin miscompares++; $display("[TB] FAIL setup_edge_ok: got %b expected 00000", viol); end
    // Rise 10 cycles after the data change: counter reads 9, a violation.
    do_reset;
    ff_data = 1'b1; tick;
    repeat (9) tick;
    ff_clock = 1'b1; tick;
    vectors++;
    if (viol !== 5'b00001) begin miscompares++; $display("[TB] FAIL setup_edge_bad: got %b expected 00001", viol); end
  endtask

  task automatic test_hold_period;
    do_reset;
    ff_clock = 1'b1; ff_data = 1'b1; tick;
    vectors++;
    if (viol !== 5'b00001) begin miscompares++; $display("[TB] FAIL hp_first_rise: got %b expected 00001", viol); end
    for (int i = 1; i < 20; i++) begin
      ff_clock = (i < 10);
      tick;
      vectors++;
      if (viol !== 5'b00000) begin miscompares++; $display("[TB] FAIL hp_quiet cycle %0d: got %b expected 00000", i, viol); end
    end
    ff_clock = 1'b1; tick;
    vectors++;
    if (viol !== 5'b00100) begin miscompares++; $display("[TB] FAIL hp_period: got %b expected 00100", viol); end
    vectors++;
    if (sticky !== 5'b00101) begin miscompares++; $display("[TB] FAIL hp_sticky: got %b expected 00101", sticky); end
    vectors++;
    if (notifier !== 1'b0) begin miscompares++; $display("[TB] FAIL hp_notifier: got %b expected 0", notifier); end
  endtask

  task automatic test_clr_sticky_hold;
    do_reset;
    ff_data = 1'b1; tick;
    ff_clock = 1'b1; tick;
    vectors++;
    if (viol !== 5'b00001) begin miscompares++; $display("[TB] FAIL cs_setup: got %b expected 00001", viol); end
    ff_data = 1'b0; clr_sticky = 1'b1; tick;
    vectors++;
    if (viol !== 5'b00010) begin miscompares++; $display("[TB] FAIL cs_hold: got %b expected 00010", viol); end
    vectors++;
    if (sticky !== 5'b00010) begin miscompares++; $display("[TB] FAIL cs_sticky_collide: got %b expected 00010", sticky); end
    vectors++;
    if (notifier !== 1'b0) begin miscompares++; $display("[TB] FAIL cs_notifier: got %b expected 0", notifier); end
    tick;
    vectors++;
    if (sticky !== 5'b00000) begin miscompares++; $display("[TB] FAIL cs_sticky_clear: got %b expected 00000", sticky); end
    clr_sticky = 1'b0;
  endtask

  task automatic test_width_recovery;
    do_reset;
    ff_preset = 1'b0; tick;
    vectors++;
    if (viol !== 5'b00000) begin miscompares++; $display("[TB] FAIL wr_fall: got %b expected 00000", viol); end
    repeat (5) tick;
    ff_preset = 1'b1; tick;
    vectors++;
    if (viol !== 5'b01000) begin miscompares++; $display("[TB] FAIL wr_width: got %b expected 01000", viol); end
    vectors++;
    if (notifier !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_notifier1: got %b expected 1", notifier); end
    tick;
    ff_clock = 1'b1; tick;
    vectors++;
    if (viol !== 5'b10000) begin miscompares++; $display("[TB] FAIL wr_recovery: got %b expected 10000", viol); end
    vectors++;
    if (notifier !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_notifier2: got %b expected 0", notifier); end
    vectors++;
    if (sticky !== 5'b11000) begin miscompares++; $display("[TB] FAIL wr_sticky: got %b expected 11000", sticky); end
  endtask

  task automatic test_clean;
    do_reset;
    for (int c = 0; c <= 90; c++) begin
      if (c % 30 == 0) ff_clock = 1'b1;
      if (c % 30 == 15) begin ff_clock = 1'b0; ff_data = ~ff_data; end
      tick;
      vectors++;
      if (viol !== 5'b00000 || notifier !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL clean cycle %0d: got viol=%b notifier=%b expected 00000/0", c, viol, notifier);
      end
    end
    vectors++;
    if (sticky !== 5'b00000) begin miscompares++; $display("[TB] FAIL clean_sticky: got %b expected 00000", sticky); end
  endtask

  task automatic test_reset_abort;
    do_reset;
    ff_data = 1'b1; tick;
    reset = 1'b1; tick;
    vectors++;
    if (viol !== 5'b00000) begin miscompares++; $display("[TB] FAIL abort_in_reset: got %b expected 00000", viol); end
    reset = 1'b0; tick;
    tick;
    ff_clock = 1'b1; tick;
    vectors++;
    if (viol !== 5'b00000) begin miscompares++; $display("[TB] FAIL abort_viol: got %b expected 00000", viol); end
    vectors++;
    if (notifier !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_notifier: got %b expected 0", notifier); end
    vectors++;
    if (sticky !== 5'b00000) begin miscompares++; $display("[TB] FAIL abort_sticky: got %b expected 00000", sticky); end
`ifdef DFF_TMON_COUNT_EN
    vectors++;
    if (count !== 16'd0) begin miscompares++; $display("[TB] FAIL abort_count: got %0d expected 0", count); end
`endif
  endtask

  // Scenario sequence, each starting from its own reset.
  initial begin
    reset = 1'b1;
    ff_clock = 1'b0; ff_data = 1'b0; ff_preset = 1'b1; ff_clear = 1'b1;
    clr_sticky = 1'b0;
    test_reset;
    test_setup;
    test_setup_boundary;
    test_hold_period;
    test_clr_sticky_hold;
    test_width_recovery;
    test_clean;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
